// File: rtl/fw_cfg_static_pkg.sv
// Shared types and field positions for the static configuration endpoint.
package fw_cfg_static_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_LOAD     = 3'd3
  } ser_state_t;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_DONE      = 1;
  localparam int unsigned STAT_ERR       = 2;
  localparam int unsigned STAT_STATE_LSB = 3;
  localparam int unsigned STAT_STATE_MSB = 5;
  localparam int unsigned STAT_COUNT_LSB = 8;
  localparam int unsigned STAT_COUNT_MSB = 15;
  localparam int unsigned STAT_BITS_LSB  = 16;
  localparam int unsigned STAT_BITS_MSB  = 31;

  localparam int unsigned BODY_ADDR_LSB = 16;
  localparam int unsigned BODY_ADDR_MSB = 23;
  localparam int unsigned BODY_DATA_LSB = 0;
  localparam int unsigned BODY_DATA_MSB = 15;

  // Bit positions of the op strobes inside the packed op vector
  localparam int unsigned OP_W_EXECUTE = 0;
  localparam int unsigned OP_R_STATUS  = 1;
  localparam int unsigned OP_R_CFG     = 2;
  localparam int unsigned OP_W_CFG     = 3;
  localparam int unsigned OP_W_RST     = 4;

endpackage

// File: rtl/fw_cfg_serializer.sv
// Shifts the flat config image out over sclk/sdata, then pulses sload.
module fw_cfg_serializer
  import fw_cfg_static_pkg::*;
#(
  parameter int unsigned CFG_DEPTH = 16,
  parameter int unsigned CFG_WIDTH = 16,
  parameter int unsigned SCLK_DIV  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [CFG_DEPTH*CFG_WIDTH-1:0] mem,
  output logic                           busy,
  output logic                           done_pulse,
  output logic [15:0]                    bit_cnt,
  output ser_state_t                     state,
  output logic                           cfg_sclk,
  output logic                           cfg_sdata,
  output logic                           cfg_sload
);

  localparam int unsigned NBITS    = CFG_DEPTH * CFG_WIDTH;
  localparam logic [15:0] NBITS16  = 16'(NBITS);
  localparam logic [15:0] DIV_LAST = 16'(SCLK_DIV - 1);

  ser_state_t       state_n;
  logic [15:0]      div_cnt;
  logic             div_last;
  logic             last_bit;
  logic             bit_step;
  logic [NBITS-1:0] mem_shift;
  logic             next_bit;

  assign div_last  = (div_cnt == DIV_LAST);
  assign last_bit  = (bit_cnt == 16'd1);
  assign bit_step  = (state == ST_SHIFT_HI) && div_last && !abort;
  // Flat image MSB is word DEPTH-1 bit W-1, so bits go out from the top down
  assign mem_shift = mem >> (bit_cnt - 16'd2);
  assign next_bit  = mem_shift[0];
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_n    = state;
    done_pulse = 1'b0;
    if (abort) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (start) state_n = ST_SHIFT_LO;
        ST_SHIFT_LO: if (div_last) state_n = ST_SHIFT_HI;
        ST_SHIFT_HI: if (div_last) state_n = last_bit ? ST_LOAD : ST_SHIFT_LO;
        ST_LOAD: begin
          if (div_last) begin
            state_n    = ST_IDLE;
            done_pulse = 1'b1;
          end
        end
        default:     state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      cfg_sclk  <= 1'b0;
      cfg_sdata <= 1'b0;
      cfg_sload <= 1'b0;
    end else begin
      state     <= state_n;
      cfg_sclk  <= (state_n == ST_SHIFT_HI);
      cfg_sload <= (state_n == ST_LOAD);
      if (abort || state == ST_IDLE || div_last)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + 16'd1;
      if (abort) begin
        bit_cnt   <= '0;
        cfg_sdata <= 1'b0;
      end else if (state == ST_IDLE && start) begin
        bit_cnt   <= NBITS16;
        cfg_sdata <= mem[NBITS-1];
      end else if (bit_step) begin
        bit_cnt <= bit_cnt - 16'd1;
        if (!last_bit) cfg_sdata <= next_bit;
      end
    end
  end

endmodule

// File: rtl/fw_ip1_cfg_static.sv
// Firmware endpoint: command detect, static config file, read mux, status.
module fw_ip1_cfg_static
  import fw_cfg_static_pkg::*;
#(
  parameter int unsigned FW_INDEX  = 0,
  parameter int unsigned CFG_DEPTH = 16,
  parameter int unsigned CFG_WIDTH = 16,
  parameter int unsigned SCLK_DIV  = 4
) (
  input  logic        fw_pl_clk1,
  input  logic        fw_rst_n,
  input  logic [3:0]  fw_dev_id_enable,
  input  logic        fw_op_code_w_reset,
  input  logic        fw_op_code_w_cfg_static_0,
  input  logic        fw_op_code_r_cfg_static_0,
  input  logic        fw_op_code_r_status,
  input  logic        fw_op_code_w_execute,
  input  logic [23:0] sw_write24_0,
  output logic [31:0] fw_read_data32,
  output logic [31:0] fw_read_status32,
  output logic        cfg_sclk,
  output logic        cfg_sdata,
  output logic        cfg_sload
);

  localparam int unsigned NBITS = CFG_DEPTH * CFG_WIDTH;

  logic [3:0]           en_vec;
  logic                 en;
  logic [4:0]           ops;
  logic [28:0]          cmd;
  logic [28:0]          cmd_q;
  logic                 new_cmd;
  logic [4:0]           op_q;
  logic [7:0]           addr;
  logic [CFG_WIDTH-1:0] wdata;
  logic                 addr_ok;
  logic                 do_rst, do_wcfg, do_rcfg, do_rstat, do_exec;
  logic                 start;
  logic [NBITS-1:0]     mem_flat;
  logic [15:0]          rd_word;
  logic [31:0]          status;
  logic                 done, err;
  logic [7:0]           cmd_count;
  logic                 busy, done_pulse;
  logic [15:0]          bit_cnt;
  ser_state_t           ser_state;

  assign en_vec = fw_dev_id_enable >> FW_INDEX;
  assign en     = en_vec[0];
  assign ops    = {fw_op_code_w_reset, fw_op_code_w_cfg_static_0, fw_op_code_r_cfg_static_0,
                   fw_op_code_r_status, fw_op_code_w_execute};
  assign cmd    = {ops, sw_write24_0};

  // en is left out of the compare so re-enabling with a held command does not retrigger
  always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      cmd_q   <= '0;
      new_cmd <= 1'b0;
    end else begin
      cmd_q   <= cmd;
      new_cmd <= en && (cmd != cmd_q) && $onehot(ops);
    end
  end

  assign op_q     = cmd_q[28:24];
  assign addr     = cmd_q[BODY_ADDR_MSB:BODY_ADDR_LSB];
  assign wdata    = cmd_q[BODY_DATA_LSB+CFG_WIDTH-1:BODY_DATA_LSB];
  assign addr_ok  = ({1'b0, addr} < 9'(CFG_DEPTH));
  assign do_rst   = new_cmd && op_q[OP_W_RST];
  assign do_wcfg  = new_cmd && op_q[OP_W_CFG];
  assign do_rcfg  = new_cmd && op_q[OP_R_CFG];
  assign do_rstat = new_cmd && op_q[OP_R_STATUS];
  assign do_exec  = new_cmd && op_q[OP_W_EXECUTE];
  assign start    = do_exec && !busy;

  always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      mem_flat <= '0;
    end else if (do_rst) begin
      mem_flat <= '0;
    end else if (do_wcfg && addr_ok && !busy) begin
      for (int unsigned i = 0; i < CFG_DEPTH; i++)
        if (addr == 8'(i)) mem_flat[i*CFG_WIDTH +: CFG_WIDTH] <= wdata;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < CFG_DEPTH; i++)
      if (addr == 8'(i)) rd_word = 16'(mem_flat[i*CFG_WIDTH +: CFG_WIDTH]);
  end

  always_comb begin
    status                                = '0;
    status[STAT_BUSY]                     = busy;
    status[STAT_DONE]                     = done;
    status[STAT_ERR]                      = err;
    status[STAT_STATE_MSB:STAT_STATE_LSB] = ser_state;
    status[STAT_COUNT_MSB:STAT_COUNT_LSB] = cmd_count;
    status[STAT_BITS_MSB:STAT_BITS_LSB]   = bit_cnt;
  end

  assign fw_read_status32 = status;

  always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      done           <= 1'b0;
      err            <= 1'b0;
      cmd_count      <= '0;
      fw_read_data32 <= '0;
    end else if (do_rst) begin
      done           <= 1'b0;
      err            <= 1'b0;
      cmd_count      <= '0;
      fw_read_data32 <= '0;
    end else begin
      if (new_cmd) cmd_count <= cmd_count + 8'd1;
      if (start)
        done <= 1'b0;
      else if (done_pulse)
        done <= 1'b1;
      if ((do_wcfg && (!addr_ok || busy)) || (do_rcfg && !addr_ok) || (do_exec && busy))
        err <= 1'b1;
      if (do_rcfg)
        fw_read_data32 <= {8'h00, addr, (addr_ok ? rd_word : 16'h0000)};
      else if (do_rstat)
        fw_read_data32 <= status;
    end
  end

  fw_cfg_serializer #(
    .CFG_DEPTH (CFG_DEPTH),
    .CFG_WIDTH (CFG_WIDTH),
    .SCLK_DIV  (SCLK_DIV)
  ) u_ser (
    .clk        (fw_pl_clk1),
    .rst_n      (fw_rst_n),
    .start      (start),
    .abort      (do_rst),
    .mem        (mem_flat),
    .busy       (busy),
    .done_pulse (done_pulse),
    .bit_cnt    (bit_cnt),
    .state      (ser_state),
    .cfg_sclk   (cfg_sclk),
    .cfg_sdata  (cfg_sdata),
    .cfg_sload  (cfg_sload)
  );

endmodule

// File: tb/tb_fw_ip1_cfg_static.sv
// Scoreboard bench for fw_ip1_cfg_static: timed expectations plus serial-stream queue.
module tb_fw_ip1_cfg_static;

  localparam logic [4:0] NOOP   = 5'b00000;
  localparam logic [4:0] W_RST  = 5'b10000;
  localparam logic [4:0] W_CFG  = 5'b01000;
  localparam logic [4:0] R_CFG  = 5'b00100;
  localparam logic [4:0] R_STAT = 5'b00010;
  localparam logic [4:0] W_EXEC = 5'b00001;

  localparam int SEL_RD  = 0;
  localparam int SEL_ST  = 1;
  localparam int SEL_PIN = 2;

  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [31:0] mask;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  dev_en;
  logic        op_rst, op_wcfg, op_rcfg, op_rstat, op_exec;
  logic [23:0] body;
  logic [31:0] rd_data, st_data;
  logic        sclk, sdata, sload;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          bit_idx = 0;
  exp_t        exp_q[$];
  logic        bit_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fw_ip1_cfg_static #(
    .FW_INDEX  (0),
    .CFG_DEPTH (16),
    .CFG_WIDTH (16),
    .SCLK_DIV  (4)
  ) dut (
    .fw_pl_clk1                (clk),
    .fw_rst_n                  (rst_n),
    .fw_dev_id_enable          (dev_en),
    .fw_op_code_w_reset        (op_rst),
    .fw_op_code_w_cfg_static_0 (op_wcfg),
    .fw_op_code_r_cfg_static_0 (op_rcfg),
    .fw_op_code_r_status       (op_rstat),
    .fw_op_code_w_execute      (op_exec),
    .sw_write24_0              (body),
    .fw_read_data32            (rd_data),
    .fw_read_status32          (st_data),
    .cfg_sclk                  (sclk),
    .cfg_sdata                 (sdata),
    .cfg_sload                 (sload)
  );

  function automatic void expect_at(input int unsigned c, input int sel, input logic [31:0] mask,
                                    input logic [31:0] exp, input string name);
    exp_t e;
    e.cyc = c; e.sel = sel; e.mask = mask; e.exp = exp; e.name = name;
    exp_q.push_back(e);
  endfunction

  // Stream of mem[15]=16'h8001 with every other word zero, first nbits of it
  function automatic void push_stream(input int nbits);
    for (int i = 0; i < nbits; i++) bit_q.push_back((i == 0) || (i == 15));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int unsigned c);
    while (cyc < c) step();
  endtask

  task automatic drive(input logic [4:0] ops, input logic [23:0] b, output int unsigned t);
    {op_rst, op_wcfg, op_rcfg, op_rstat, op_exec} = ops;
    body = b;
    t = cyc + 1;
  endtask

  task automatic issue(input logic [4:0] ops, input logic [23:0] b, output int unsigned t);
    step();
    drive(ops, b, t);
  endtask

  // Monitor: compares whatever expectations fall due this cycle, and each sclk rise
  initial begin
    logic        prev_sclk;
    logic [31:0] act;
    logic        eb;
    prev_sclk = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
        if (exp_q[i].cyc == cyc) begin
          case (exp_q[i].sel)
            SEL_RD:  act = rd_data;
            SEL_ST:  act = st_data;
            default: act = {29'b0, sclk, sdata, sload};
          endcase
          n_cmp++;
          if ((act & exp_q[i].mask) !== (exp_q[i].exp & exp_q[i].mask)) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h (masked %h) want %h", exp_q[i].name, cyc,
                     act, act & exp_q[i].mask, exp_q[i].exp & exp_q[i].mask);
          end
          exp_q.delete(i);
        end
      end
      if (sclk && !prev_sclk) begin
        n_cmp++;
        if (bit_q.size() == 0) begin
          n_err++;
          $display("FAIL stream_extra @cyc %0d: got sclk rise want no bit", cyc);
        end else begin
          eb = bit_q.pop_front();
          if (sdata !== eb) begin
            n_err++;
            $display("FAIL stream_bit %0d @cyc %0d: got %b want %b", bit_idx, cyc, sdata, eb);
          end
        end
        bit_idx++;
      end
      prev_sclk = sclk;
    end
  end

  initial begin
    int unsigned t, t2;
    rst_n  = 1'b0;
    dev_en = 4'b0001;
    {op_rst, op_wcfg, op_rcfg, op_rstat, op_exec} = NOOP;
    body   = '0;
    repeat (3) step();
    rst_n = 1'b1;

    expect_at(cyc + 1, SEL_ST,  32'hFFFF_FFFF, 32'h0, "rst_status");
    expect_at(cyc + 1, SEL_RD,  32'hFFFF_FFFF, 32'h0, "rst_rdata");
    expect_at(cyc + 1, SEL_PIN, 32'h7, 32'h0, "rst_pins");

    issue(R_STAT, 24'h0, t);
    expect_at(t + 1, SEL_RD, 32'hFFFF_FFFF, 32'h0, "rstatus_snapshot");
    expect_at(t + 1, SEL_ST, 32'h0000_FF00, 32'h0000_0100, "count_after_rstatus");

    issue(W_CFG, 24'h03A5C3, t);
    issue(NOOP, 24'h0, t);
    issue(R_CFG, 24'h030000, t);
    expect_at(t + 1, SEL_RD, 32'hFFFF_FFFF, 32'h0003_A5C3, "rcfg_addr3");
    expect_at(t + 1, SEL_ST, 32'h0000_FF00, 32'h0000_0300, "count_3");

    issue(W_CFG, 24'h101234, t);
    expect_at(t + 1, SEL_ST, 32'h0000_FF04, 32'h0000_0404, "wcfg_bad_addr_err");
    issue(R_CFG, 24'h100000, t);
    expect_at(t + 1, SEL_RD, 32'hFFFF_FFFF, 32'h0010_0000, "rcfg_bad_addr");
    issue(R_CFG, 24'h030000, t);
    expect_at(t + 1, SEL_RD, 32'hFFFF_FFFF, 32'h0003_A5C3, "mem_unchanged");

    issue(W_RST, 24'h0, t);
    expect_at(t + 1, SEL_RD, 32'hFFFF_FFFF, 32'h0, "wrst_rdata");
    expect_at(t + 1, SEL_ST, 32'hFFFF_FFFF, 32'h0, "wrst_status");
    issue(R_CFG, 24'h030000, t);
    expect_at(t + 1, SEL_RD, 32'hFFFF_FFFF, 32'h0003_0000, "rcfg_after_wrst");
    expect_at(t + 1, SEL_ST, 32'h0000_FF07, 32'h0000_0100, "status_after_wrst");

    // Held command is not retriggered; a NOOP in between re-arms it
    issue(R_STAT, 24'h0, t);
    expect_at(t + 1, SEL_RD, 32'hFFFF_FFFF, 32'h0000_0100, "rstatus_count1");
    issue(R_STAT, 24'h0, t);
    expect_at(t + 3, SEL_ST, 32'h0000_FF00, 32'h0000_0200, "repeat_no_trigger");
    repeat (3) step();
    issue(NOOP, 24'h0, t);
    issue(R_STAT, 24'h0, t);
    expect_at(t + 1, SEL_RD, 32'hFFFF_FFFF, 32'h0000_0200, "rstatus_after_noop");
    expect_at(t + 1, SEL_ST, 32'h0000_FF00, 32'h0000_0300, "count_after_noop");

    step();
    dev_en = 4'b0000;
    drive(W_CFG, 24'h017777, t);
    expect_at(t + 2, SEL_ST, 32'h0000_FF00, 32'h0000_0300, "disabled_ignored");
    repeat (3) step();
    dev_en = 4'b0001;
    expect_at(cyc + 3, SEL_ST, 32'h0000_FF00, 32'h0000_0300, "reenable_no_trigger");
    repeat (4) step();
    issue(R_CFG, 24'h010000, t);
    expect_at(t + 1, SEL_RD, 32'hFFFF_FFFF, 32'h0001_0000, "disabled_write_dropped");
    expect_at(t + 1, SEL_ST, 32'h0000_FF00, 32'h0000_0400, "count_4");

    // Undisturbed shift of mem[15]=8001
    issue(W_RST, 24'h0, t);
    issue(W_CFG, 24'h0F8001, t);
    issue(W_EXEC, 24'h0, t);
    push_stream(256);
    expect_at(t + 1, SEL_ST, 32'hFFFF_0039, 32'h0100_0009, "exec_enter_shift_lo");
    expect_at(t + 1, SEL_PIN, 32'h7, 32'h2, "exec_first_bit");
    expect_at(t + 4, SEL_PIN, 32'h4, 32'h0, "sclk_low_before_rise");
    expect_at(t + 5, SEL_PIN, 32'h4, 32'h4, "sclk_first_rise");
    expect_at(t + 2048, SEL_PIN, 32'h1, 32'h0, "sload_before");
    expect_at(t + 2049, SEL_PIN, 32'h1, 32'h1, "sload_first");
    expect_at(t + 2052, SEL_PIN, 32'h1, 32'h1, "sload_last");
    expect_at(t + 2052, SEL_ST, 32'h3, 32'h1, "busy_before_done");
    expect_at(t + 2053, SEL_PIN, 32'h1, 32'h0, "sload_after");
    expect_at(t + 2053, SEL_ST, 32'h3, 32'h2, "done_set");
    goto(t + 2060);

    // Writes and execute while busy are rejected without touching the stream
    issue(NOOP, 24'h0, t);
    issue(W_EXEC, 24'h0, t);
    push_stream(256);
    expect_at(t + 1, SEL_ST, 32'h7, 32'h1, "exec2_done_cleared");
    goto(t + 499);
    drive(W_CFG, 24'h00FFFF, t2);
    expect_at(t2 + 1, SEL_ST, 32'h5, 32'h5, "wcfg_busy_err");
    issue(W_EXEC, 24'h0, t2);
    expect_at(t2 + 1, SEL_ST, 32'h7, 32'h5, "exec_busy_err");
    expect_at(t + 2049, SEL_PIN, 32'h1, 32'h1, "exec2_sload");
    expect_at(t + 2053, SEL_ST, 32'h3, 32'h2, "exec2_done");
    goto(t + 2060);
    issue(R_CFG, 24'h000000, t);
    expect_at(t + 1, SEL_RD, 32'hFFFF_FFFF, 32'h0, "busy_write_dropped");

    // W_RST mid-shift aborts the serialiser
    issue(NOOP, 24'h0, t);
    issue(W_EXEC, 24'h0, t);
    push_stream(37);
    goto(t + 299);
    drive(W_RST, 24'h0, t2);
    expect_at(t + 302, SEL_PIN, 32'h7, 32'h0, "abort_pins");
    expect_at(t + 302, SEL_ST, 32'hFFFF_FFFF, 32'h0, "abort_status");
    goto(t + 340);

    issue(NOOP, 24'h0, t);
    repeat (5) step();
    while (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got unchecked want checked at cyc %0d", exp_q[0].name, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (bit_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL stream_short: got %0d bits missing want 0", bit_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
